// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller
// Purpose  : Bridges a 32-bit MEM-stage load/store port to a 16-bit
//            asynchronous SRAM. Each word access is split into a low half
//            and a high half. Each half is held on the SRAM pins for
//            WAIT_CYC cycles. ready is low while an access is in flight, so
//            the pipeline freeze signal is simply ~ready.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WAIT_CYC    cycles per 16-bit half access (1..15)
// Build option
//   SRAM_READ_CACHE_EN  when defined, adds a one-entry cache of the last read
//                       word, so a repeated read completes in one cycle
// Ports
//   clk, rst    clock; asynchronous active-high reset
//   wr_en       write request, held until ready
//   rd_en       read request, held until ready (wr_en wins if both are set)
//   address     byte address; [18:2] selects the 32-bit word
//   write_data  word to store
//   read_data   last word read; valid when ready=1 after a read
//   ready       high when idle without a request, or when an access completes
//   sram_addr   half-word SRAM address {word, half}
//   sram_dq_out write data to the SRAM, driven when sram_dq_oe=1
//   sram_dq_oe  data bus drive enable
//   sram_dq_in  read data from the SRAM
//   sram_we_n   active-low SRAM write strobe
// ============================================================================
module sram_controller #(
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // The counter runs from WAIT_CYC-1 down to 0, so each half lasts WAIT_CYC cycles.
  localparam logic [3:0] C_CNT_LOAD = 4'(WAIT_CYC - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic [16:0] word_q, word_d;
  logic [31:0] read_data_q, read_data_d;

  logic        req;

`ifdef SRAM_READ_CACHE_EN
  logic        cache_valid_q, cache_valid_d;
  logic [16:0] cache_tag_q, cache_tag_d;
  logic [31:0] cache_data_q, cache_data_d;
  logic        cache_hit;
`endif

  // Only address bits [18:2] select a word. The remaining bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, address[31:19], address[1:0]};

  assign req = wr_en | rd_en;

`ifdef SRAM_READ_CACHE_EN
  // A write request takes priority, so it never counts as a hit.
  assign cache_hit = rd_en & ~wr_en & cache_valid_q & (cache_tag_q == address[18:2]);
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      is_write_q    <= 1'b0;
      word_q        <= 17'd0;
      read_data_q   <= 32'd0;
`ifdef SRAM_READ_CACHE_EN
      cache_valid_q <= 1'b0;
      cache_tag_q   <= 17'd0;
      cache_data_q  <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_write_q    <= is_write_d;
      word_q        <= word_d;
      read_data_q   <= read_data_d;
`ifdef SRAM_READ_CACHE_EN
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_write_d    = is_write_q;
    word_d        = word_q;
    read_data_d   = read_data_q;
`ifdef SRAM_READ_CACHE_EN
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef SRAM_READ_CACHE_EN
        if (cache_hit) begin
          state_d     = S_DONE;
          read_data_d = cache_data_q;
        end else
`endif
        if (req) begin
          // Latch the operation type and word so that the SRAM pins stay
          // stable for the whole access.
          state_d    = S_LOW;
          cnt_d      = C_CNT_LOAD;
          is_write_d = wr_en;
          word_d     = address[18:2];
`ifdef SRAM_READ_CACHE_EN
          if (wr_en && (cache_tag_q == address[18:2])) begin
            cache_valid_d = 1'b0;
          end
`endif
        end
      end

      S_LOW: begin
        if (!req) begin
          // The request was withdrawn. Abandon the access, but keep any
          // half that has already been written.
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_HIGH;
          cnt_d   = C_CNT_LOAD;
          if (!is_write_q) begin
            read_data_d[15:0] = sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_HIGH: begin
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (!is_write_q) begin
            read_data_d[31:16] = sram_dq_in;
`ifdef SRAM_READ_CACHE_EN
            cache_valid_d = 1'b1;
            cache_tag_d   = word_q;
            cache_data_d  = {sram_dq_in, read_data_q[15:0]};
`endif
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        // A request seen here belongs to the access just completed. It is
        // ignored, and a request that is still held restarts from IDLE.
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    ready       = 1'b0;
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;

    case (state_q)
      S_IDLE: ready = ~req;
      S_LOW: begin
        sram_addr = {word_q, 1'b0};
        if (is_write_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = write_data[15:0];
        end
      end
      S_HIGH: begin
        sram_addr = {word_q, 1'b1};
        if (is_write_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = write_data[31:16];
        end
      end
      S_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign read_data = read_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_controller
// Purpose  : Directed self-checking bench for sram_controller with WAIT_CYC=2.
//            A small 16-bit SRAM array stands in for the device. The cache
//            scenario is selected with SRAM_READ_CACHE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  int vecs = 0;
  int errs = 0;

  logic [15:0] mem [0:1023];
  logic        mem_clr;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYC(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
  );

  // SRAM model: combinational read, write on each clock edge while strobed.
  wire unused_tb_bits = &{1'b0, sram_addr[17:10]};
  assign sram_dq_in = mem[sram_addr[9:0]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
    end else if (!sram_we_n && sram_dq_oe) begin
      mem[sram_addr[9:0]] <= sram_dq_out;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Counts clock edges until ready rises, stopping after 20 edges.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!ready && n < 20);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    mem_clr = 1'b0;
    #1;
    if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", ready); end
    vecs++;
    if (sram_we_n !== 1'b1) begin errs++; $display("FAIL reset_we_n: got %b want 1", sram_we_n); end
    vecs++;
    if (sram_dq_oe !== 1'b0) begin errs++; $display("FAIL reset_oe: got %b want 0", sram_dq_oe); end
    vecs++;
    if (sram_addr !== 18'h0) begin errs++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
    vecs++;
    if (sram_dq_out !== 16'h0) begin errs++; $display("FAIL reset_dq_out: got %h want 0", sram_dq_out); end
    vecs++;
    if (read_data !== 32'h0) begin errs++; $display("FAIL reset_read_data: got %h want 0", read_data); end
    vecs++;
    #3 rst = 1'b0;
    cycle();
  endtask

  task automatic test_write();
    logic [17:0] ea;
    logic [15:0] ed;
    address = 32'h0000_0404; write_data = 32'hDEAD_BEEF; wr_en = 1'b1;
    #1;
    if (ready !== 1'b0) begin errs++; $display("FAIL wr_req_ready: got %b want 0", ready); end
    vecs++;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      ea = (k <= 2) ? 18'h202 : 18'h203;
      ed = (k <= 2) ? 16'hBEEF : 16'hDEAD;
      if (sram_addr !== ea || sram_dq_out !== ed || sram_we_n !== 1'b0 ||
          sram_dq_oe !== 1'b1 || ready !== 1'b0) begin
        errs++;
        $display("FAIL wr_cycle%0d: got addr=%h dq=%h we_n=%b oe=%b rdy=%b want addr=%h dq=%h we_n=0 oe=1 rdy=0",
                 k, sram_addr, sram_dq_out, sram_we_n, sram_dq_oe, ready, ea, ed);
      end
      vecs++;
    end
    cycle();
    if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_addr !== 18'h0) begin
      errs++;
      $display("FAIL wr_done: got rdy=%b we_n=%b addr=%h want 1 1 0", ready, sram_we_n, sram_addr);
    end
    vecs++;
    wr_en = 1'b0;
    cycle();
    if (ready !== 1'b1) begin errs++; $display("FAIL wr_idle_ready: got %b want 1", ready); end
    vecs++;
    if (mem[10'h202] !== 16'hBEEF || mem[10'h203] !== 16'hDEAD) begin
      errs++;
      $display("FAIL wr_mem: got %h/%h want beef/dead", mem[10'h202], mem[10'h203]);
    end
    vecs++;
  endtask

  task automatic test_read();
    logic [17:0] ea;
    address = 32'h0000_0404; rd_en = 1'b1;
    #1;
    if (ready !== 1'b0) begin errs++; $display("FAIL rd_req_ready: got %b want 0", ready); end
    vecs++;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      ea = (k <= 2) ? 18'h202 : 18'h203;
      if (sram_addr !== ea || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || ready !== 1'b0) begin
        errs++;
        $display("FAIL rd_cycle%0d: got addr=%h we_n=%b oe=%b rdy=%b want addr=%h we_n=1 oe=0 rdy=0",
                 k, sram_addr, sram_we_n, sram_dq_oe, ready, ea);
      end
      vecs++;
    end
    cycle();
    if (ready !== 1'b1 || read_data !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL rd_done: got rdy=%b data=%h want 1 deadbeef", ready, read_data);
    end
    vecs++;
    rd_en = 1'b0;
    cycle();
    if (read_data !== 32'hDEAD_BEEF) begin errs++; $display("FAIL rd_hold: got %h want deadbeef", read_data); end
    vecs++;
  endtask

  task automatic test_abort();
    address = 32'h0000_0500; rd_en = 1'b1;
    cycle();
    if (sram_addr !== 18'h280 || ready !== 1'b0) begin
      errs++;
      $display("FAIL ab_rd_low: got addr=%h rdy=%b want 280 0", sram_addr, ready);
    end
    vecs++;
    rd_en = 1'b0;
    cycle();
    if (ready !== 1'b1 || sram_addr !== 18'h0 || read_data !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL ab_rd_idle: got rdy=%b addr=%h data=%h want 1 0 deadbeef", ready, sram_addr, read_data);
    end
    vecs++;
    address = 32'h0000_0600; write_data = 32'h1111_2222; wr_en = 1'b1;
    cycle();
    if (sram_we_n !== 1'b0 || sram_addr !== 18'h300) begin
      errs++;
      $display("FAIL ab_wr_low: got we_n=%b addr=%h want 0 300", sram_we_n, sram_addr);
    end
    vecs++;
    wr_en = 1'b0;
    cycle();
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || ready !== 1'b1) begin
      errs++;
      $display("FAIL ab_wr_idle: got we_n=%b oe=%b rdy=%b want 1 0 1", sram_we_n, sram_dq_oe, ready);
    end
    vecs++;
    if (mem[10'h300] !== 16'h2222 || mem[10'h301] !== 16'h0000) begin
      errs++;
      $display("FAIL ab_wr_mem: got %h/%h want 2222/0000", mem[10'h300], mem[10'h301]);
    end
    vecs++;
  endtask

  task automatic test_reset_mid();
    address = 32'h0000_040C; write_data = 32'hAAAA_5555; wr_en = 1'b1;
    repeat (3) cycle();
    if (sram_addr !== 18'h207 || sram_we_n !== 1'b0 || sram_dq_out !== 16'hAAAA) begin
      errs++;
      $display("FAIL rm_high: got addr=%h we_n=%b dq=%h want 207 0 aaaa", sram_addr, sram_we_n, sram_dq_out);
    end
    vecs++;
    #2 rst = 1'b1;
    #1;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'h0 ||
        sram_dq_out !== 16'h0 || read_data !== 32'h0) begin
      errs++;
      $display("FAIL rm_async: got we_n=%b oe=%b addr=%h dq=%h data=%h want 1 0 0 0 0",
               sram_we_n, sram_dq_oe, sram_addr, sram_dq_out, read_data);
    end
    vecs++;
    wr_en = 1'b0;
    #1;
    if (ready !== 1'b1) begin errs++; $display("FAIL rm_ready: got %b want 1", ready); end
    vecs++;
    #2 rst = 1'b0;
    cycle();
    if (mem[10'h206] !== 16'h5555 || mem[10'h207] !== 16'h0000) begin
      errs++;
      $display("FAIL rm_mem: got %h/%h want 5555/0000", mem[10'h206], mem[10'h207]);
    end
    vecs++;
  endtask

  task automatic test_priority();
    int n;
    address = 32'h0000_0408; write_data = 32'h1234_5678; wr_en = 1'b1; rd_en = 1'b1;
    cycle();
    if (sram_we_n !== 1'b0 || sram_dq_out !== 16'h5678) begin
      errs++;
      $display("FAIL pr_low: got we_n=%b dq=%h want 0 5678", sram_we_n, sram_dq_out);
    end
    vecs++;
    wait_ready(n);
    if (n !== 4) begin errs++; $display("FAIL pr_latency: got %0d want 4 more edges", n); end
    vecs++;
    wr_en = 1'b0; rd_en = 1'b0;
    cycle();
    if (read_data !== 32'h0) begin errs++; $display("FAIL pr_read_data: got %h want 0", read_data); end
    vecs++;
    if (mem[10'h204] !== 16'h5678 || mem[10'h205] !== 16'h1234) begin
      errs++;
      $display("FAIL pr_mem: got %h/%h want 5678/1234", mem[10'h204], mem[10'h205]);
    end
    vecs++;
  endtask

`ifdef SRAM_READ_CACHE_EN
  task automatic test_cache();
    int n;
    address = 32'h0000_0404; rd_en = 1'b1;
    wait_ready(n);
    if (n !== 5 || read_data !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL ca_miss: got n=%0d data=%h want 5 deadbeef", n, read_data);
    end
    vecs++;
    rd_en = 1'b0;
    cycle();
    rd_en = 1'b1;
    #1;
    if (ready !== 1'b0) begin errs++; $display("FAIL ca_req_ready: got %b want 0", ready); end
    vecs++;
    wait_ready(n);
    if (n !== 1 || read_data !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL ca_hit: got n=%0d data=%h want 1 deadbeef", n, read_data);
    end
    vecs++;
    rd_en = 1'b0;
    cycle();
    write_data = 32'h0BAD_F00D; wr_en = 1'b1;
    wait_ready(n);
    wr_en = 1'b0;
    cycle();
    rd_en = 1'b1;
    wait_ready(n);
    if (n !== 5 || read_data !== 32'h0BAD_F00D) begin
      errs++;
      $display("FAIL ca_after_wr: got n=%0d data=%h want 5 0badf00d", n, read_data);
    end
    vecs++;
    rd_en = 1'b0;
    cycle();
  endtask
`else
  task automatic test_back_to_back();
    int n;
    address = 32'h0000_0404;
    for (int r = 0; r < 2; r++) begin
      rd_en = 1'b1;
      wait_ready(n);
      if (n !== 5 || read_data !== 32'hDEAD_BEEF) begin
        errs++;
        $display("FAIL b2b_read%0d: got n=%0d data=%h want 5 deadbeef", r, n, read_data);
      end
      vecs++;
      rd_en = 1'b0;
      cycle();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_reset_mid();
    test_priority();
`ifdef SRAM_READ_CACHE_EN
    test_cache();
`else
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
